// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_pkg
// Description : Shared definitions for the perceptron predict/train units:
//               state encoding, packed-vector field offsets, accumulator
//               width formula and offset-binary weight decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Signed accumulator width that covers bias plus HISTORY worst-case terms
    function automatic int sum_width(input int bias_w, input int word_w, input int history);
        return ((bias_w > word_w) ? bias_w : word_w) + $clog2(history + 2) + 1;
    endfunction

    // LSB of the bias field, which occupies the top BIAS bits of the vector
    function automatic int bias_lsb(input int weigth_w, input int bias_w);
        return weigth_w - bias_w;
    endfunction

    // LSB of weight word i
    function automatic int word_lsb(input int i, input int word_w);
        return word_w * i;
    endfunction

    // Offset-binary word to signed value: value = word - 2^(word_w-1)
    function automatic int offset_to_signed(input logic [31:0] word, input int word_w);
        return int'(word) - (1 << (word_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_term.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_term
// Description : One accumulation lane. Decodes an offset-binary weight word
//               and applies its history bit as sign (+v taken, -v not taken).
//               A disabled lane (index beyond the history) contributes zero.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_term
    import perceptron_pkg::*;
#(
    parameter int WIDTH_WORD = 4,
    parameter int SUM_W      = 8
) (
    input  logic [WIDTH_WORD-1:0]   word,
    input  logic                    hist,
    input  logic                    enable,
    output logic signed [SUM_W-1:0] term
);

    logic signed [SUM_W-1:0] value;

    // Decode the word at full accumulator width so negating -2^(W-1) is exact
    always_comb begin
        value = SUM_W'(offset_to_signed(32'(word), WIDTH_WORD));
        term  = '0;
        if (enable) begin
            term = hist ? value : -value;
        end
    end

endmodule
`default_nettype wire

// File: rtl/perceptron_predict.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_predict
// Description : Serial perceptron inference. Computes
//               y = bias + sum(h_i ? w_i : -w_i), LANES terms per cycle, and
//               reports prediction, |y| and the training-needed flag.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_predict
    import perceptron_pkg::*;
#(
    parameter int HISTORY    = 8,
    parameter int BIAS       = 4,
    parameter int WIDTH_WORD = 4,
    parameter int WEIGTH     = BIAS + HISTORY * WIDTH_WORD,
    parameter int LANES      = 2,
    parameter int THETA      = 3,
    parameter int SUM_W      = sum_width(BIAS, WIDTH_WORD, HISTORY)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [HISTORY-1:0]      global_history_reg,
    input  logic [WEIGTH-1:0]       weigth,
    output logic                    ready,
    output logic                    busy,
    output logic                    valid,
    output logic                    prediction,
    output logic signed [SUM_W-1:0] sum,
    output logic [SUM_W-2:0]        confidence,
    output logic                    train_needed
);

    localparam int IDX_W   = $clog2(HISTORY + LANES + 1);
    localparam int WORDS_W = HISTORY * WIDTH_WORD;
    localparam int SHIFT_W = LANES * WIDTH_WORD;
    localparam logic [IDX_W-1:0] LANES_C   = IDX_W'(LANES);
    localparam logic [IDX_W-1:0] HISTORY_C = IDX_W'(HISTORY);
    localparam logic [SUM_W-2:0] THETA_C   = (SUM_W-1)'(THETA);

    state_t                  state;
    logic [WORDS_W-1:0]      word_sr;   // latched words, lane 0 always at bit 0
    logic [HISTORY-1:0]      hist_sr;   // latched history, shifted alongside
    logic [IDX_W-1:0]        idx;
    logic signed [SUM_W-1:0] acc;

    logic signed [SUM_W-1:0] lane_term [LANES];
    logic signed [SUM_W-1:0] lane_sum;
    logic signed [SUM_W-1:0] acc_next;
    logic signed [SUM_W-1:0] bias_ext;
    logic [BIAS-1:0]         bias_field;
    logic [IDX_W-1:0]        idx_next;
    logic                    last_group;
    logic [SUM_W-2:0]        acc_mag;

    assign ready = (state != ACCUM);
    assign busy  = (state == ACCUM);

    assign bias_field = weigth[bias_lsb(WEIGTH, BIAS) +: BIAS];
    assign bias_ext   = {{(SUM_W - BIAS){bias_field[BIAS-1]}}, bias_field};

    // Lanes see the low words of the shift register; indices past HISTORY are masked
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] lane_idx;
        assign lane_idx = idx + IDX_W'(l);

        perceptron_term #(
            .WIDTH_WORD (WIDTH_WORD),
            .SUM_W      (SUM_W)
        ) u_term (
            .word   (word_sr[word_lsb(l, WIDTH_WORD) +: WIDTH_WORD]),
            .hist   (hist_sr[l]),
            .enable (lane_idx < HISTORY_C),
            .term   (lane_term[l])
        );
    end

    // Sum of this cycle's lanes, next accumulator value and its magnitude
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + lane_term[l];
        end
        acc_next   = acc + lane_sum;
        idx_next   = idx + LANES_C;
        last_group = (idx_next >= HISTORY_C);
        acc_mag    = acc_next[SUM_W-1] ? (SUM_W-1)'(-acc_next) : acc_next[SUM_W-2:0];
    end

    // Control FSM, accumulator and registered result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            word_sr      <= '0;
            hist_sr      <= '0;
            idx          <= '0;
            acc          <= '0;
            valid        <= 1'b0;
            prediction   <= 1'b0;
            sum          <= '0;
            confidence   <= '0;
            train_needed <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    valid <= 1'b0;
                    if (start) begin
                        word_sr <= weigth[WORDS_W-1:0];
                        hist_sr <= global_history_reg;
                        acc     <= bias_ext;
                        idx     <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc     <= acc_next;
                    idx     <= idx_next;
                    word_sr <= word_sr >> SHIFT_W;
                    hist_sr <= hist_sr >> LANES;
                    if (last_group) begin
                        state        <= DONE;
                        valid        <= 1'b1;
                        sum          <= acc_next;
                        prediction   <= ~acc_next[SUM_W-1];
                        confidence   <= acc_mag;
                        train_needed <= (acc_mag <= THETA_C);
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
